// File: rtl/gamepad_reader_if.sv
// rtl/gamepad_reader_if.sv - SNES gamepad PMOD serial bus (latch / clock / data)
interface gamepad_reader_if;
  logic pad_data;
  logic pad_latch;
  logic pad_clk;

  modport master (
    input  pad_data,
    output pad_latch,
    output pad_clk
  );

  modport slave (
    output pad_data,
    input  pad_latch,
    input  pad_clk
  );
endinterface

// File: rtl/gamepad_reader.sv
// rtl/gamepad_reader.sv - SNES gamepad poller: latches, shifts 16 active-low bits, publishes decoded buttons
module gamepad_reader #(
  parameter int HALF_PERIOD   = 150,
  parameter int POLL_INTERVAL = 416667,
  parameter int NUM_BITS      = 16
) (
  input  logic             clk,
  input  logic             reset,
  gamepad_reader_if.master pad,
  output logic             up,
  output logic             down,
  output logic             left,
  output logic             right,
  output logic             attack,
  output logic [11:0]      buttons,
  output logic             pad_present,
  output logic             frame_done
);

  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam int CW = $clog2(POLL_INTERVAL);
  localparam int BW = $clog2(NUM_BITS);

  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_INTERVAL - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SAMPLE,
    S_CLK_LOW,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_phase;
  logic [CW-1:0]       r_poll;
  logic [BW-1:0]       r_bit;
  logic [NUM_BITS-1:0] r_raw;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_pad_latch;
  logic                r_pad_clk;
  logic                r_up;
  logic                r_down;
  logic                r_left;
  logic                r_right;
  logic                r_attack;
  logic [11:0]         r_buttons;
  logic                r_present;
  logic                r_frame_done;

  logic                w_present;
  logic [11:0]         w_buttons;

  // An unplugged pad reads all zeros through the board pull-down.
  assign w_present = |r_raw;
  assign w_buttons = w_present ? ~r_raw[11:0] : 12'h000;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_poll       <= '0;
      r_bit        <= '0;
      r_raw        <= '0;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_pad_latch  <= 1'b0;
      r_pad_clk    <= 1'b1;
      r_up         <= 1'b0;
      r_down       <= 1'b0;
      r_left       <= 1'b0;
      r_right      <= 1'b0;
      r_attack     <= 1'b0;
      r_buttons    <= '0;
      r_present    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_sync1      <= pad.pad_data;
      r_sync2      <= r_sync1;
      r_frame_done <= 1'b0;
      if (r_poll != '0) begin
        r_poll <= r_poll - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_poll == '0) begin
            r_state     <= S_LATCH;
            r_pad_latch <= 1'b1;
            r_phase     <= LATCH_LAST;
            r_poll      <= POLL_LAST;
            r_bit       <= '0;
          end
        end
        S_LATCH: begin
          if (r_phase == '0) begin
            r_state     <= S_SAMPLE;
            r_pad_latch <= 1'b0;
            r_phase     <= HALF_LAST;
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        S_SAMPLE: begin
          if (r_phase == '0) begin
            r_raw[r_bit] <= r_sync2;
            r_state      <= S_CLK_LOW;
            r_pad_clk    <= 1'b0;
            r_phase      <= HALF_LAST;
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        S_CLK_LOW: begin
          if (r_phase == '0) begin
            r_pad_clk <= 1'b1;
            if (r_bit == BIT_LAST) begin
              r_state <= S_DONE;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_state <= S_SAMPLE;
              r_phase <= HALF_LAST;
            end
          end else begin
            r_phase <= r_phase - 1'b1;
          end
        end
        S_DONE: begin
          r_present    <= w_present;
          r_buttons    <= w_buttons;
          r_up         <= w_buttons[4];
          r_down       <= w_buttons[5];
          r_left       <= w_buttons[6];
          r_right      <= w_buttons[7];
          r_attack     <= w_buttons[0] | w_buttons[8];
          r_frame_done <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pad.pad_latch = r_pad_latch;
  assign pad.pad_clk   = r_pad_clk;
  assign up            = r_up;
  assign down          = r_down;
  assign left          = r_left;
  assign right         = r_right;
  assign attack        = r_attack;
  assign buttons       = r_buttons;
  assign pad_present   = r_present;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_gamepad_reader.sv
// tb/tb_gamepad_reader.sv - bench for gamepad_reader with a behavioural SNES pad and a frame scoreboard
module tb_gamepad_reader;
  localparam int HP = 4;
  localparam int PI = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        up, down, left, right, attack, pad_present, frame_done;
  logic [11:0] buttons;

  always #5 clk = ~clk;

  gamepad_reader_if pad_if();

  gamepad_reader #(.HALF_PERIOD(HP), .POLL_INTERVAL(PI), .NUM_BITS(16)) dut (
    .clk(clk), .reset(reset), .pad(pad_if),
    .up(up), .down(down), .left(left), .right(right), .attack(attack),
    .buttons(buttons), .pad_present(pad_present), .frame_done(frame_done)
  );

  typedef struct packed {
    logic        present;
    logic [11:0] buttons;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = -1;
  int          fall_cnt = 0;
  int          fall_base = 0;
  int          pad_edges = 0;
  int          edge_base = 0;
  int          hold_err = 0;
  int          pad_idx;
  logic [15:0] pad_word = 16'hFFFF;
  logic [15:0] pad_shift = 16'hFFFF;
  bit          pad_absent = 1'b0;
  bit          skew_en = 1'b0;
  logic [17:0] prev_out;
  logic [17:0] cur_out;

  always @(posedge clk) cyc <= reset ? cyc + 1 : -1;

  // Pad model: word captured at latch, LSB first, advances after each pad_clk rise.
  assign pad_idx = pad_edges - edge_base;
  assign pad_if.pad_data = pad_absent ? 1'b0 :
                           (pad_idx >= 0 && pad_idx < 16) ? pad_shift[pad_idx[3:0]] : 1'b1;

  always @(posedge pad_if.pad_latch) begin
    pad_shift = pad_word;
    edge_base = pad_edges;
    fall_base = fall_cnt;
  end

  always @(posedge pad_if.pad_clk) begin
    if (skew_en && $urandom_range(0, 1) == 1) @(posedge clk);
    #1 pad_edges = pad_edges + 1;
  end

  always @(negedge pad_if.pad_clk) fall_cnt = fall_cnt + 1;

  assign cur_out = {up, down, left, right, attack, pad_present, buttons};
  always @(negedge clk) begin
    if (!reset || frame_done) prev_out = cur_out;
    else if (cur_out !== prev_out) begin
      hold_err = hold_err + 1;
      prev_out = cur_out;
    end
  end

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({pad_if.pad_latch, pad_if.pad_clk, frame_done} !== 3'b010) begin
      fails++; $display("FAIL reset_bus: latch/clk/frame got %b want 010", {pad_if.pad_latch, pad_if.pad_clk, frame_done});
    end
    tests++;
    if (cur_out !== 18'h0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", cur_out);
    end
  endtask

  task automatic test_idle_frame();
    bit ok;
    exp_t e;
    pad_word = 16'hFFFF;
    sb.push_back('{1'b1, 12'h000});
    reset = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      tests++;
      if (pad_if.pad_latch !== (k < 8) || cyc !== k) begin
        fails++; $display("FAIL latch_window: cyc %0d latch %b want cyc %0d latch %b", cyc, pad_if.pad_latch, k, (k < 8));
      end
    end
    wait_frame(ok);
    tests++;
    if (!ok || cyc !== 137) begin
      fails++; $display("FAIL frame_time: got cyc %0d ok %b want 137", cyc, ok);
    end
    e = sb.pop_front();
    tests++;
    if ({pad_present, buttons} !== {e.present, e.buttons}) begin
      fails++; $display("FAIL idle_decode: got %h want %h", {pad_present, buttons}, {e.present, e.buttons});
    end
    tests++;
    if (fall_cnt - fall_base !== 16) begin
      fails++; $display("FAIL clk_pulses: got %0d want 16", fall_cnt - fall_base);
    end
    sb.push_back('{1'b1, 12'h000});
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (pad_if.pad_latch === 1'b1) ok = 1'b1;
    end
    tests++;
    if (!ok || cyc !== 200) begin
      fails++; $display("FAIL next_latch: got cyc %0d want 200", cyc);
    end
    wait_frame(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || cyc !== 337 || {pad_present, buttons} !== {e.present, e.buttons}) begin
      fails++; $display("FAIL second_frame: cyc %0d got %h want 337 %h", cyc, {pad_present, buttons}, {e.present, e.buttons});
    end
  endtask

  task automatic test_direction();
    bit ok;
    exp_t e;
    pad_word = 16'hFFEE;
    sb.push_back('{1'b1, 12'h011});
    wait_frame(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || {pad_present, buttons} !== {e.present, e.buttons}) begin
      fails++; $display("FAIL dir_decode: got %h want %h", {pad_present, buttons}, {e.present, e.buttons});
    end
    tests++;
    if ({up, down, left, right, attack} !== 5'b10001) begin
      fails++; $display("FAIL dir_levels: got %b want 10001", {up, down, left, right, attack});
    end
    @(negedge clk);
    tests++;
    if (frame_done !== 1'b0) begin
      fails++; $display("FAIL frame_pulse: got %b want 0", frame_done);
    end
    sb.push_back('{1'b1, 12'h011});
    repeat (100) @(negedge clk);
    tests++;
    if (buttons !== 12'h011 || up !== 1'b1) begin
      fails++; $display("FAIL dir_hold: got %h want 011", buttons);
    end
    wait_frame(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || buttons !== e.buttons) begin
      fails++; $display("FAIL dir_repeat: got %h want %h", buttons, e.buttons);
    end
  endtask

  task automatic test_attack_release();
    bit ok;
    exp_t e;
    pad_word = 16'hFEFF;
    sb.push_back('{1'b1, 12'h100});
    wait_frame(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || buttons !== e.buttons || attack !== 1'b1) begin
      fails++; $display("FAIL a_press: got %h/%b want %h/1", buttons, attack, e.buttons);
    end
    pad_word = 16'hFFFF;
    sb.push_back('{1'b1, 12'h000});
    wait_frame(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || buttons !== e.buttons || attack !== 1'b0) begin
      fails++; $display("FAIL a_release: got %h/%b want %h/0", buttons, attack, e.buttons);
    end
    tests++;
    if (hold_err !== 0) begin
      fails++; $display("FAIL output_hold: got %0d changes want 0", hold_err);
    end
  endtask

  task automatic test_absent();
    bit ok;
    exp_t e;
    pad_absent = 1'b1;
    sb.push_back('{1'b0, 12'h000});
    wait_frame(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || {pad_present, buttons} !== {e.present, e.buttons} || {up, down, left, right, attack} !== 5'b0) begin
      fails++; $display("FAIL absent: got %h want %h", cur_out, {5'b0, e.present, e.buttons});
    end
    pad_absent = 1'b0;
  endtask

  task automatic test_reset_midshift();
    bit ok;
    exp_t e;
    pad_word = 16'hFF0F;
    sb.push_back('{1'b1, 12'h0F0});
    wait_frame(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || buttons !== e.buttons || {up, down, left, right, attack} !== 5'b11110) begin
      fails++; $display("FAIL pre_reset: got %h want %h", buttons, e.buttons);
    end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (pad_if.pad_latch === 1'b1) ok = 1'b1;
    end
    repeat (60) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({pad_if.pad_latch, pad_if.pad_clk, frame_done} !== 3'b010 || cur_out !== 18'h0) begin
      fails++; $display("FAIL abort: bus %b out %h want 010 0", {pad_if.pad_latch, pad_if.pad_clk, frame_done}, cur_out);
    end
    pad_word = 16'h0A5C;
    sb.push_back('{1'b1, 12'h5A3});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (pad_if.pad_latch !== 1'b1 || cyc !== 0) begin
      fails++; $display("FAIL relatch: latch %b cyc %0d want 1 0", pad_if.pad_latch, cyc);
    end
    wait_frame(ok);
    e = sb.pop_front();
    tests++;
    if (!ok || cyc !== 137 || {pad_present, buttons} !== {e.present, e.buttons} ||
        {up, down, left, right, attack} !== 5'b01011) begin
      fails++; $display("FAIL post_reset: cyc %0d got %h want 137 %h", cyc, cur_out, {5'b01011, e.present, e.buttons});
    end
  endtask

  task automatic test_random_words();
    bit ok;
    exp_t e;
    logic [15:0] w;
    logic [11:0] eb;
    skew_en = 1'b1;
    for (int n = 0; n < 50; n++) begin
      w = 16'($urandom);
      eb = w[11:0];
      eb = (w != 16'h0) ? ~eb : 12'h000;
      pad_word = w;
      sb.push_back('{(w != 16'h0), eb});
      wait_frame(ok);
      e = sb.pop_front();
      tests++;
      if (!ok || {pad_present, buttons} !== {e.present, e.buttons}) begin
        fails++; $display("FAIL random_word %h: got %h want %h", w, {pad_present, buttons}, {e.present, e.buttons});
      end
    end
    skew_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_frame();
    test_direction();
    test_attack_release();
    test_absent();
    test_reset_midshift();
    test_random_words();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gamepad_reader.md
Name: gamepad_reader

Overview:
- Serial master for an SNES-protocol gamepad on the gamepad PMOD (latch / clock / data).
- Polls the pad at a fixed interval and decodes the 16-bit active-low shift word.
- Drives registered, level-type up/down/left/right/attack signals into the input edge-detection stage.
- Also exposes the full 12-button word and a pad-present flag.

Parameters:
HALF_PERIOD, 150, clk cycles per serial-clock half period and per half of the latch pulse; must be >= 4
POLL_INTERVAL, 416667, clk cycles between successive latch rising edges (~60 Hz at 25 MHz); must be > 34*HALF_PERIOD+1
NUM_BITS, 16, serial bits read per poll; fixed at 16

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
pad_data  input  1  serial data from pad; low = pressed; asynchronous
pad_latch  output  1  latch pulse to pad, active-high
pad_clk  output  1  serial clock to pad; idles high
up  output  1  up pressed (registered level)
down  output  1  down pressed
left  output  1  left pressed
right  output  1  right pressed
attack  output  1  B or A pressed
buttons  output  12  decoded pressed mask; bit order [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R
pad_present  output  1  last poll saw a connected pad
frame_done  output  1  one-cycle pulse when outputs update

Behaviour:
- Reset: reset, synchronous, active-low; clock clk.
  - While reset is low: pad_latch=0, pad_clk=1, all button outputs 0, pad_present=0, frame_done=0, FSM=IDLE, poll counter preloaded to expire.
  - Reset mid-transaction aborts immediately; no partial word is published.
- pad_data passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- FSM states: IDLE, LATCH, SAMPLE, CLK_LOW, DONE. Each timed state uses one phase counter that reloads on state entry.
  - IDLE: pad_latch=0, pad_clk=1. Go to LATCH when the poll counter expires. The first expiry is the first cycle after reset deasserts.
  - LATCH: pad_latch=1, pad_clk=1, lasts 2*HALF_PERIOD cycles. Bit counter cleared. Poll counter restarts at LATCH entry.
  - SAMPLE: pad_latch=0, pad_clk=1, lasts HALF_PERIOD cycles. On its last cycle, shift the synchronized data into bit[bit_count] of the raw register (LSB first), then go to CLK_LOW.
  - CLK_LOW: pad_clk=0, lasts HALF_PERIOD cycles. If bit_count==15, go to DONE; else increment bit_count and go to SAMPLE.
    - 16 falling edges of pad_clk per poll.
    - The pad advances on pad_clk rising edges.
  - DONE: one cycle. On the edge ending DONE, outputs update atomically, frame_done=1 for exactly one cycle, FSM returns to IDLE.
- Decode (at DONE):
  - pad_present = (raw != 16'h0000). The data line has a board pull-down, so an absent pad reads all zeros.
  - If present: buttons = ~raw[11:0]; raw[15:12] are ignored.
  - If absent: buttons = 0.
  - up=buttons[4], down=buttons[5], left=buttons[6], right=buttons[7], attack=buttons[0]|buttons[8].
- Outputs hold between polls. No change except at the DONE edge or on reset.
- Transaction length is 34*HALF_PERIOD+1 cycles. Latch-to-latch period is exactly POLL_INTERVAL cycles.
- With HALF_PERIOD=4 (cycle 0 = first cycle after reset release):
  - latch high cycles 0-7
  - bit n sampled at cycle 11+8n
  - last CLK_LOW at cycles 132-135, DONE at 136
  - outputs and frame_done visible at cycle 137

Test Plan:
1. HALF_PERIOD=4, POLL_INTERVAL=200; pad model drives raw=16'hFFFF (no buttons) -> pad_latch high cycles 0-7; exactly 16 pad_clk low pulses; frame_done at cycle 137; pad_present=1; buttons=0; next latch rise at cycle 200.
2. Pad drives raw with bits 4 and 0 low (16'hFFEE) -> buttons=12'h011, up=1, attack=1, down/left/right=0; values held unchanged until the next frame_done.
3. Pad holds A low only (16'hFEFF) -> attack=1, buttons=12'h100. Next poll releases it (16'hFFFF) -> attack=0 exactly at the second frame_done.
4. pad_data tied low (absent) -> pad_present=0, buttons=0, all direction/attack outputs 0.
5. Assert reset at cycle 60 (mid-shift) after a poll with buttons=12'h0F0 -> next edge: pad_clk=1, pad_latch=0, outputs 0, no frame_done. After release: fresh latch on the first cycle and correct decode.
6. Pad changes pad_data only on pad_clk rising edges, with a random 0-1 cycle skew -> all 16 bits are captured correctly across 50 random words.
